// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS32 decode stage.
//   - opcode and funct encodings of the supported instruction subset
//   - 4-bit ALU operation codes consumed by EX
//   - immediate-extension modes, destination selects and the control bundle
//   - extend_imm(): builds the 32-bit immediate from instr[15:0]
package mips_pkg;

   localparam int unsigned BusWidth = 32;

   // Opcodes
   localparam logic [5:0] OpRType = 6'h00;
   localparam logic [5:0] OpAddi  = 6'h08;
   localparam logic [5:0] OpAndi  = 6'h0C;
   localparam logic [5:0] OpOri   = 6'h0D;
   localparam logic [5:0] OpSlti  = 6'h0A;
   localparam logic [5:0] OpLui   = 6'h0F;
   localparam logic [5:0] OpLw    = 6'h23;
   localparam logic [5:0] OpSw    = 6'h2B;
   localparam logic [5:0] OpBeq   = 6'h04;

   // R-type funct codes
   localparam logic [5:0] FnAdd = 6'h20;
   localparam logic [5:0] FnSub = 6'h22;
   localparam logic [5:0] FnAnd = 6'h24;
   localparam logic [5:0] FnOr  = 6'h25;
   localparam logic [5:0] FnSlt = 6'h2A;

   typedef enum logic [3:0] {
      AluAdd = 4'd0,
      AluSub = 4'd1,
      AluAnd = 4'd2,
      AluOr  = 4'd3,
      AluSlt = 4'd4,
      AluLui = 4'd5
   } alu_op_e;

   typedef enum logic [1:0] {
      ImmSign,
      ImmZero,
      ImmLui
   } imm_mode_e;

   typedef enum logic [1:0] {
      DestNone,
      DestRt,
      DestRd
   } dest_sel_e;

   typedef struct packed {
      logic alu_src_imm;
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic branch;
   } ctrl_t;

   function automatic logic [BusWidth-1:0] extend_imm(input logic [15:0] imm,
                                                     input imm_mode_e mode);
      logic [BusWidth-1:0] res;
      unique case (mode)
         ImmZero: res = {16'h0000, imm};
         ImmLui:  res = {imm, 16'h0000};
         default: res = {{16{imm[15]}}, imm};
      endcase
      return res;
   endfunction

endpackage

// File: rtl/decode_ctrl.sv
// decode_ctrl: combinational opcode/funct decoder.
// Ports:
//   opcode_i, funct_i  instruction fields [31:26] and [5:0]
//   legal_o            instruction is in the supported subset
//   alu_op_o           ALU operation for EX
//   ctrl_o             alu_src_imm / reg_write / mem_read / mem_write / branch
//   imm_mode_o         how the 16-bit immediate is extended
//   dest_sel_o         which field names the destination register
//   use_rs_o, use_rt_o source registers actually read (for hazard detection)
module decode_ctrl
   import mips_pkg::*;
(
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   output logic       legal_o,
   output alu_op_e    alu_op_o,
   output ctrl_t      ctrl_o,
   output imm_mode_e  imm_mode_o,
   output dest_sel_e  dest_sel_o,
   output logic       use_rs_o,
   output logic       use_rt_o
);

   always_comb begin
      legal_o    = 1'b1;
      alu_op_o   = AluAdd;
      ctrl_o     = '0;
      imm_mode_o = ImmSign;
      dest_sel_o = DestNone;
      use_rs_o   = 1'b1;
      use_rt_o   = 1'b0;

      case (opcode_i)
         OpRType: begin
            use_rt_o         = 1'b1;
            dest_sel_o       = DestRd;
            ctrl_o.reg_write = 1'b1;
            case (funct_i)
               FnAdd:   alu_op_o = AluAdd;
               FnSub:   alu_op_o = AluSub;
               FnAnd:   alu_op_o = AluAnd;
               FnOr:    alu_op_o = AluOr;
               FnSlt:   alu_op_o = AluSlt;
               default: legal_o  = 1'b0;
            endcase
         end
         OpAddi, OpAndi, OpOri, OpSlti, OpLui, OpLw: begin
            dest_sel_o         = DestRt;
            ctrl_o.reg_write   = 1'b1;
            ctrl_o.alu_src_imm = 1'b1;
            case (opcode_i)
               OpAndi:  begin alu_op_o = AluAnd; imm_mode_o = ImmZero; end
               OpOri:   begin alu_op_o = AluOr;  imm_mode_o = ImmZero; end
               OpSlti:  alu_op_o = AluSlt;
               OpLui:   begin alu_op_o = AluLui; imm_mode_o = ImmLui; use_rs_o = 1'b0; end
               OpLw:    ctrl_o.mem_read = 1'b1;
               default: alu_op_o = AluAdd;
            endcase
         end
         OpSw: begin
            use_rt_o           = 1'b1;
            ctrl_o.alu_src_imm = 1'b1;
            ctrl_o.mem_write   = 1'b1;
         end
         OpBeq: begin
            // Offset stays in words; EX applies the shift.
            use_rt_o      = 1'b1;
            alu_op_o      = AluSub;
            ctrl_o.branch = 1'b1;
         end
         default: legal_o = 1'b0;
      endcase

      // Illegal encodings become bubbles and must never trigger a stall.
      if (!legal_o) begin
         alu_op_o = AluAdd;
         ctrl_o   = '0;
         use_rs_o = 1'b0;
         use_rt_o = 1'b0;
      end
   end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: MIPS32 ID stage feeding the ID/EX pipeline register.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ifValid/ifInstr/ifPc     instruction from IF; ifReady = accepted this cycle
//   flush                    taken branch downstream, discard current decode
//   dirA/dirB, outA/outB     combinational register file read port
//   wbEnWrite/wbDir/wbData   WB write, bypassed into the operands
//   ex*                      ID/EX register contents
module decode_stage
   import mips_pkg::*;
#(
   parameter int unsigned BUS_SIZE          = 32,
   parameter int unsigned DIR_SIZE_INTERNAL = 5
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ifValid,
   input  logic [BUS_SIZE-1:0]          ifInstr,
   input  logic [BUS_SIZE-1:0]          ifPc,
   output logic                         ifReady,
   input  logic                         flush,
   output logic [DIR_SIZE_INTERNAL-1:0] dirA,
   output logic [DIR_SIZE_INTERNAL-1:0] dirB,
   input  logic [BUS_SIZE-1:0]          outA,
   input  logic [BUS_SIZE-1:0]          outB,
   input  logic                         wbEnWrite,
   input  logic [DIR_SIZE_INTERNAL-1:0] wbDir,
   input  logic [BUS_SIZE-1:0]          wbData,
   output logic                         exValid,
   output logic [BUS_SIZE-1:0]          exOpA,
   output logic [BUS_SIZE-1:0]          exOpB,
   output logic [BUS_SIZE-1:0]          exImm,
   output logic [DIR_SIZE_INTERNAL-1:0] exDirDest,
   output logic [3:0]                   exAluOp,
   output logic                         exAluSrcImm,
   output logic                         exRegWrite,
   output logic                         exMemRead,
   output logic                         exMemWrite,
   output logic                         exBranch,
   output logic [BUS_SIZE-1:0]          exPc
);

   logic                         legal;
   alu_op_e                      alu_op;
   ctrl_t                        ctrl;
   imm_mode_e                    imm_mode;
   dest_sel_e                    dest_sel;
   logic                         use_rs, use_rt;
   logic [DIR_SIZE_INTERNAL-1:0] rd, dest;
   logic [BUS_SIZE-1:0]          op_a, op_b;
   logic                         hazard, load;
   logic [4:0]                   unused_shamt;

   logic                         valid_q;
   ctrl_t                        ctrl_q, ctrl_d;
   logic [3:0]                   alu_op_q;
   logic [BUS_SIZE-1:0]          op_a_q, op_b_q, imm_q, pc_q;
   logic [DIR_SIZE_INTERNAL-1:0] dest_q;

   assign dirA         = ifInstr[25:21];
   assign dirB         = ifInstr[20:16];
   assign rd           = ifInstr[15:11];
   assign unused_shamt = ifInstr[10:6];

   decode_ctrl u_decode_ctrl (
      .opcode_i   (ifInstr[31:26]),
      .funct_i    (ifInstr[5:0]),
      .legal_o    (legal),
      .alu_op_o   (alu_op),
      .ctrl_o     (ctrl),
      .imm_mode_o (imm_mode),
      .dest_sel_o (dest_sel),
      .use_rs_o   (use_rs),
      .use_rt_o   (use_rt)
   );

   // r0 reads as zero; a same-cycle WB write wins over the stale file value.
   always_comb begin
      op_a = outA;
      if (dirA == '0) op_a = '0;
      else if (wbEnWrite && wbDir == dirA) op_a = wbData;
      op_b = outB;
      if (dirB == '0) op_b = '0;
      else if (wbEnWrite && wbDir == dirB) op_b = wbData;
   end

   always_comb begin
      dest = '0;
      unique case (dest_sel)
         DestRt:  dest = dirB;
         DestRd:  dest = rd;
         default: dest = '0;
      endcase
   end

   // A load in EX whose result is read here cannot be bypassed yet.
   assign hazard = valid_q && ctrl_q.mem_read && dest_q != '0 && ifValid &&
                   ((use_rs && dirA == dest_q) || (use_rt && dirB == dest_q));

   assign ifReady = !rst && (flush || !hazard);
   assign load    = !flush && !hazard && ifValid && legal;

   always_comb begin
      ctrl_d = '0;
      if (load) begin
         ctrl_d           = ctrl;
         ctrl_d.reg_write = ctrl.reg_write && (dest != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= 1'b0;
         ctrl_q   <= '0;
         alu_op_q <= '0;
         op_a_q   <= '0;
         op_b_q   <= '0;
         imm_q    <= '0;
         dest_q   <= '0;
         pc_q     <= '0;
      end else begin
         valid_q  <= load;
         ctrl_q   <= ctrl_d;
         alu_op_q <= load ? alu_op : AluAdd;
         // Data fields are don't-care in a bubble, so they load unconditionally.
         op_a_q   <= op_a;
         op_b_q   <= op_b;
         imm_q    <= extend_imm(ifInstr[15:0], imm_mode);
         dest_q   <= dest;
         pc_q     <= ifPc;
      end
   end

   assign exValid     = valid_q;
   assign exOpA       = op_a_q;
   assign exOpB       = op_b_q;
   assign exImm       = imm_q;
   assign exDirDest   = dest_q;
   assign exAluOp     = alu_op_q;
   assign exAluSrcImm = ctrl_q.alu_src_imm;
   assign exRegWrite  = ctrl_q.reg_write;
   assign exMemRead   = ctrl_q.mem_read;
   assign exMemWrite  = ctrl_q.mem_write;
   assign exBranch    = ctrl_q.branch;
   assign exPc        = pc_q;

endmodule
